// File: rtl/lcd_init_seq_if.sv
// Word handshake between the LCD init sequencer and the byte-level SPI writer.
interface lcd_init_seq_if;
  logic [8:0] data;
  logic       en_write;
  logic       wr_done;

  modport master (output data, output en_write, input  wr_done);
  modport slave  (input  data, input  en_write, output wr_done);
endinterface

// File: rtl/lcd_init_seq.sv
// Power-up sequencer for the SPI LCD: panel hardware reset, then a fixed
// command/data table streamed word by word to the SPI writer with datasheet delays.
module lcd_init_seq #(
  parameter int CLK_PER_MS  = 50000,
  parameter int T_RST_MS    = 10,
  parameter int T_SLPOUT_MS = 120,
  parameter int WR_TIMEOUT  = 1023
) (
  input  logic           sys_clk_50MHz,
  input  logic           sys_rst,
  input  logic           start,
  lcd_init_seq_if.master wr_if,
  output logic           lcd_rst,
  output logic           busy,
  output logic           init_done,
  output logic           err
);

  localparam int MS_MAX = (T_RST_MS > T_SLPOUT_MS) ? T_RST_MS : T_SLPOUT_MS;
  localparam int PRE_W  = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam int MS_W   = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;
  localparam int WT_W   = (WR_TIMEOUT > 1) ? $clog2(WR_TIMEOUT) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(CLK_PER_MS - 1);
  localparam logic [MS_W-1:0]  RST_MS_LAST = MS_W'(T_RST_MS - 1);
  localparam logic [MS_W-1:0]  SLP_MS_LAST = MS_W'(T_SLPOUT_MS - 1);
  localparam logic [WT_W-1:0]  WT_LAST     = WT_W'(WR_TIMEOUT - 1);
  localparam logic [2:0]       LAST_IDX    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RST_LOW   = 3'd1,
    S_RST_WAIT  = 3'd2,
    S_SEND      = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_DELAY     = 3'd5,
    S_DONE      = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [8:0]       data_q, data_d;
  logic             en_write_q, en_write_d;
  logic             lcd_rst_q, lcd_rst_d;
  logic             busy_q, busy_d;
  logic             init_done_q, init_done_d;
  logic             err_q, err_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [MS_W-1:0]  ms_q, ms_d;
  logic [WT_W-1:0]  wt_q, wt_d;

  logic             pre_wrap_s;
  logic [PRE_W-1:0] pre_nxt_s;
  logic [MS_W-1:0]  ms_nxt_s;
  logic             rst_elapsed_s;
  logic             slp_elapsed_s;

  function automatic logic [8:0] init_word(input logic [2:0] i);
    case (i)
      3'd0:    init_word = 9'h011;
      3'd1:    init_word = 9'h036;
      3'd2:    init_word = 9'h100;
      3'd3:    init_word = 9'h03A;
      3'd4:    init_word = 9'h105;
      3'd5:    init_word = 9'h021;
      3'd6:    init_word = 9'h029;
      default: init_word = 9'h000;
    endcase
  endfunction

  // Shared millisecond timebase for the reset and sleep-out waits
  assign pre_wrap_s    = (pre_q == PRE_LAST);
  assign pre_nxt_s     = pre_wrap_s ? {PRE_W{1'b0}} : pre_q + PRE_W'(1);
  assign ms_nxt_s      = pre_wrap_s ? ms_q + MS_W'(1) : ms_q;
  assign rst_elapsed_s = pre_wrap_s && (ms_q == RST_MS_LAST);
  assign slp_elapsed_s = pre_wrap_s && (ms_q == SLP_MS_LAST);

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    data_d      = data_q;
    en_write_d  = 1'b0;
    lcd_rst_d   = lcd_rst_q;
    busy_d      = busy_q;
    init_done_d = init_done_q;
    err_d       = err_q;
    pre_d       = pre_q;
    ms_d        = ms_q;
    wt_d        = wt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_RST_LOW;
          lcd_rst_d   = 1'b0;
          busy_d      = 1'b1;
          init_done_d = 1'b0;
          err_d       = 1'b0;
          idx_d       = 3'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_RST_LOW: begin
        pre_d = pre_nxt_s;
        ms_d  = ms_nxt_s;
        if (rst_elapsed_s) begin
          state_d   = S_RST_WAIT;
          lcd_rst_d = 1'b1;
        end else begin
          lcd_rst_d = 1'b0;
        end
      end
      S_RST_WAIT: begin
        pre_d = pre_nxt_s;
        ms_d  = ms_nxt_s;
        if (rst_elapsed_s) begin
          state_d = S_SEND;
        end else begin
          state_d = state_q;
        end
      end
      S_SEND: begin
        data_d     = init_word(idx_q);
        en_write_d = 1'b1;
        state_d    = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        wt_d = wt_q + WT_W'(1);
        // A completion on the very last allowed cycle still wins over the timeout
        if (wr_if.wr_done) begin
          if (idx_q == 3'd0) begin
            state_d = S_DELAY;
          end else if (idx_q == LAST_IDX) begin
            state_d     = S_DONE;
            busy_d      = 1'b0;
            init_done_d = 1'b1;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_SEND;
          end
        end else if (wt_q == WT_LAST) begin
          state_d     = S_IDLE;
          err_d       = 1'b1;
          busy_d      = 1'b0;
          init_done_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_DELAY: begin
        pre_d = pre_nxt_s;
        ms_d  = ms_nxt_s;
        if (slp_elapsed_s) begin
          idx_d   = 3'd1;
          state_d = S_SEND;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        lcd_rst_d = 1'b1;
      end
    endcase

    // Every timed state starts counting from zero
    pre_d = (state_d != state_q) ? {PRE_W{1'b0}} : pre_d;
    ms_d  = (state_d != state_q) ? {MS_W{1'b0}}  : ms_d;
    wt_d  = (state_d != state_q) ? {WT_W{1'b0}}  : wt_d;
  end

  // State, counters and output registers
  always_ff @(posedge sys_clk_50MHz or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      data_q      <= 9'h000;
      en_write_q  <= 1'b0;
      lcd_rst_q   <= 1'b1;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      pre_q       <= {PRE_W{1'b0}};
      ms_q        <= {MS_W{1'b0}};
      wt_q        <= {WT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      en_write_q  <= en_write_d;
      lcd_rst_q   <= lcd_rst_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      pre_q       <= pre_d;
      ms_q        <= ms_d;
      wt_q        <= wt_d;
    end
  end

  assign wr_if.data     = data_q;
  assign wr_if.en_write = en_write_q;
  assign lcd_rst        = lcd_rst_q;
  assign busy           = busy_q;
  assign init_done      = init_done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_lcd_init_seq.sv
// Self-checking bench for lcd_init_seq: writer model plus a timeline model
// that predicts every en_write cycle and word from the sequencing rules.
module tb_lcd_init_seq;

  localparam int CPM   = 10;
  localparam int TR    = 2;
  localparam int TS    = 3;
  localparam int WT    = 100;
  localparam int N_RST = TR * CPM;
  localparam int N_SLP = TS * CPM;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic lcd_rst, busy, init_done, err;

  lcd_init_seq_if wif();

  lcd_init_seq #(
    .CLK_PER_MS(CPM), .T_RST_MS(TR), .T_SLPOUT_MS(TS), .WR_TIMEOUT(WT)
  ) dut (
    .sys_clk_50MHz(clk),
    .sys_rst(rst),
    .start(start),
    .wr_if(wif),
    .lcd_rst(lcd_rst),
    .busy(busy),
    .init_done(init_done),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lat;        // writer latency in cycles, -1 = random
    int hang_word;  // word the writer never completes, -1 = none
    bit spur;       // inject start pulses mid-sequence
    bit exp_err;
    bit exp_done;
    int exp_words;
  } vec_t;

  vec_t       vecs[8];
  logic [8:0] exp_words[7];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int lat_a[7];
  int exp_e[7];
  int n_exp_words, run_s, end_cyc, nw;
  int start_at = -1, spur_s1 = -1, spur_s2 = -1, spur_wd_at = -1, done_at = -1;
  int ew_cyc[$];
  logic [8:0] ew_dat[$];
  int rst_fall[$], rst_rise[$], done_rise[$], err_rise[$];
  int ew_wide, data_glitch;
  logic prev_ew, prev_rst, prev_done, prev_err;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk = n_chk + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // One clock: observe on the falling edge, then drive writer/start for the next rising edge
  task automatic tick();
    @(negedge clk);
    cyc = cyc + 1;
    if (wif.en_write) begin
      if (prev_ew) ew_wide = ew_wide + 1;
      ew_cyc.push_back(cyc);
      ew_dat.push_back(wif.data);
      done_at = -1;
      if (nw < 7) begin
        if (lat_a[nw] >= 0) done_at = cyc + lat_a[nw];
      end
      nw = nw + 1;
    end else if (ew_dat.size() > 0) begin
      if (wif.data != ew_dat[$]) data_glitch = data_glitch + 1;
    end
    if (prev_rst && !lcd_rst) rst_fall.push_back(cyc);
    if (!prev_rst && lcd_rst) rst_rise.push_back(cyc);
    if (!prev_done && init_done) done_rise.push_back(cyc);
    if (!prev_err && err) err_rise.push_back(cyc);
    prev_ew   = wif.en_write;
    prev_rst  = lcd_rst;
    prev_done = init_done;
    prev_err  = err;
    wif.wr_done = (cyc == done_at) || (cyc == spur_wd_at);
    start       = (cyc == start_at) || (cyc == spur_s1) || (cyc == spur_s2);
  endtask

  // Predict the whole timeline of a run from the sequencing rules
  task automatic run_setup(input vec_t v);
    run_s      = cyc + 2;
    start_at   = run_s;
    spur_wd_at = cyc + 1;
    done_at    = -1;
    spur_s1    = -1;
    spur_s2    = -1;
    for (int i = 0; i < 7; i++) begin
      lat_a[i] = (v.lat < 0) ? int'($urandom_range(WT - 1, 1)) : v.lat;
    end
    if (v.hang_word >= 0) lat_a[v.hang_word] = -1;
    n_exp_words = (v.hang_word >= 0) ? v.hang_word + 1 : 7;
    exp_e[0] = run_s + 2 * N_RST + 2;
    for (int i = 1; i < n_exp_words; i++) begin
      exp_e[i] = exp_e[i-1] + lat_a[i-1] + 2 + ((i == 1) ? N_SLP : 0);
    end
    end_cyc = (v.hang_word >= 0) ? exp_e[v.hang_word] + WT : exp_e[6] + lat_a[6] + 1;
    if (v.spur) begin
      spur_s1 = run_s + N_RST + 5;
      spur_s2 = exp_e[2] + 3;
    end
    ew_cyc.delete();
    ew_dat.delete();
    rst_fall.delete();
    rst_rise.delete();
    done_rise.delete();
    err_rise.delete();
    nw = 0;
    ew_wide = 0;
    data_glitch = 0;
    prev_ew   = wif.en_write;
    prev_rst  = lcd_rst;
    prev_done = init_done;
    prev_err  = err;
  endtask

  task automatic run_vec(input vec_t v, input int r);
    int a;
    run_setup(v);
    while (cyc < end_cyc + 5) begin
      tick();
      if (cyc == run_s + 1) begin
        chk($sformatf("r%0d_accept_busy", r), int'(busy), 1);
        chk($sformatf("r%0d_accept_init_done", r), int'(init_done), 0);
        chk($sformatf("r%0d_accept_err", r), int'(err), 0);
      end
    end
    a = (rst_fall.size() > 0) ? rst_fall[0] : -1;
    chk($sformatf("r%0d_lcd_rst_fall", r), a, run_s + 1);
    a = (rst_rise.size() > 0) ? rst_rise[0] : -1;
    chk($sformatf("r%0d_lcd_rst_rise", r), a, run_s + N_RST + 1);
    chk($sformatf("r%0d_word_count", r), nw, v.exp_words);
    for (int i = 0; i < n_exp_words; i++) begin
      a = (i < ew_cyc.size()) ? ew_cyc[i] : -1;
      chk($sformatf("r%0d_w%0d_cycle", r, i), a, exp_e[i]);
      a = (i < ew_dat.size()) ? int'(ew_dat[i]) : -1;
      chk($sformatf("r%0d_w%0d_data", r, i), a, int'(exp_words[i]));
    end
    if (ew_cyc.size() >= 2) begin
      chk($sformatf("r%0d_slpout_gap_ge_30", r), int'((ew_cyc[1] - (ew_cyc[0] + lat_a[0])) >= 30), 1);
    end
    chk($sformatf("r%0d_en_write_width", r), ew_wide, 0);
    chk($sformatf("r%0d_data_stable", r), data_glitch, 0);
    if (v.exp_done) begin
      a = (done_rise.size() > 0) ? done_rise[0] : -1;
      chk($sformatf("r%0d_init_done_cycle", r), a, end_cyc);
    end else begin
      a = (err_rise.size() > 0) ? err_rise[0] : -1;
      chk($sformatf("r%0d_err_cycle", r), a, end_cyc);
    end
    chk($sformatf("r%0d_end_busy", r), int'(busy), 0);
    chk($sformatf("r%0d_end_init_done", r), int'(init_done), int'(v.exp_done));
    chk($sformatf("r%0d_end_err", r), int'(err), int'(v.exp_err));
    chk($sformatf("r%0d_end_lcd_rst", r), int'(lcd_rst), 1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_data"}, int'(wif.data), 0);
    chk({tag, "_en_write"}, int'(wif.en_write), 0);
    chk({tag, "_lcd_rst"}, int'(lcd_rst), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_init_done"}, int'(init_done), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  initial begin
    exp_words[0] = 9'h011; exp_words[1] = 9'h036; exp_words[2] = 9'h100;
    exp_words[3] = 9'h03A; exp_words[4] = 9'h105; exp_words[5] = 9'h021;
    exp_words[6] = 9'h029;
    vecs[0] = '{20,     -1, 1'b0, 1'b0, 1'b1, 7};
    vecs[1] = '{20,      3, 1'b0, 1'b1, 1'b0, 4};
    vecs[2] = '{20,     -1, 1'b1, 1'b0, 1'b1, 7};
    vecs[3] = '{WT - 1, -1, 1'b0, 1'b0, 1'b1, 7};
    vecs[4] = '{-1,     -1, 1'b0, 1'b0, 1'b1, 7};
    vecs[5] = '{-1,     -1, 1'b0, 1'b0, 1'b1, 7};
    vecs[6] = '{-1,     -1, 1'b0, 1'b0, 1'b1, 7};
    vecs[7] = '{-1,      6, 1'b0, 1'b1, 1'b0, 7};

    rst = 1'b1;
    start = 1'b0;
    wif.wr_done = 1'b0;
    repeat (3) tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();

    for (int r = 0; r < 4; r++) run_vec(vecs[r], r);

    // Spurious wr_done while parked in DONE must change nothing
    start_at = -1; spur_s1 = -1; spur_s2 = -1; done_at = -1;
    spur_wd_at = cyc + 1;
    nw = 0;
    repeat (4) tick();
    chk("done_spur_wr_done_init_done", int'(init_done), 1);
    chk("done_spur_wr_done_busy", int'(busy), 0);
    chk("done_spur_wr_done_words", nw, 0);

    for (int r = 4; r < 8; r++) run_vec(vecs[r], r);

    // Asynchronous reset in the middle of the sleep-out delay
    run_setup(vecs[0]);
    while (cyc < exp_e[0] + lat_a[0] + 10) tick();
    chk("delay_busy_before_reset", int'(busy), 1);
    #2 rst = 1'b1;
    #1 check_reset_values("async_reset");
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_reset_values("after_reset");
    run_vec(vecs[0], 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_init_seq.md
Name: lcd_init_seq

Overview:
Power-up sequencer for the SPI LCD panel. It sits directly upstream of the byte-level SPI writer. It drives the panel hardware reset and then feeds a fixed command/data table, one 9-bit word at a time, using the writer's en_write/wr_done handshake. It inserts the datasheet delays between words and asserts init_done so the drawing logic can take over the writer.

Parameters:
CLK_PER_MS, 50000, sys_clk_50MHz cycles per millisecond (set to 10 in simulation).
T_RST_MS, 10, panel reset low time and post-reset wait, each in ms.
T_SLPOUT_MS, 120, wait after the sleep-out command, in ms.
WR_TIMEOUT, 1023, max cycles from en_write to wr_done before the sequence aborts.

Ports:
sys_clk_50MHz  input  1  system clock, 50 MHz
sys_rst  input  1  asynchronous reset, active-high
start  input  1  one-cycle pulse that starts or restarts the init sequence
wr_done  input  1  one-cycle pulse from the SPI writer when a word has been shifted out
data  output  9  {dc, byte} to the writer; bit 8 = 1 means data, 0 means command
en_write  output  1  one-cycle request to the writer
lcd_rst  output  1  panel hardware reset, active-low
busy  output  1  high from start acceptance until DONE or abort
init_done  output  1  level; high once the whole table has been sent
err  output  1  sticky; wr_done timeout occurred

Behaviour:
- Reset values (sys_rst=1): state IDLE, data=9'h000, en_write=0, lcd_rst=1, busy=0, init_done=0, err=0, all counters 0.
- Table (index: word): 0: 9'h011 (SLPOUT), 1: 9'h036, 2: 9'h100, 3: 9'h03A, 4: 9'h105, 5: 9'h021, 6: 9'h029. LAST_IDX=6.
- States: IDLE, RST_LOW, RST_WAIT, SEND, WAIT_DONE, DELAY, DONE.
- IDLE:
  - start=1 → RST_LOW next cycle.
  - On acceptance: busy=1, init_done=0, err=0, idx=0.
- RST_LOW:
  - lcd_rst=0 for exactly T_RST_MS*CLK_PER_MS cycles, then → RST_WAIT.
- RST_WAIT:
  - lcd_rst=1, wait T_RST_MS*CLK_PER_MS cycles, then → SEND.
- SEND (one cycle):
  - data <= table[idx] and en_write <= 1, both registered, so they are visible together one cycle later.
  - → WAIT_DONE.
- WAIT_DONE:
  - en_write returns to 0 after exactly one cycle.
  - data is held stable until the next SEND, because the writer's dc output follows data[8] combinationally.
  - On wr_done: if idx==0 → DELAY; else if idx==LAST_IDX → DONE; else idx+1 → SEND.
- DELAY:
  - Wait T_SLPOUT_MS*CLK_PER_MS cycles, then idx=1 → SEND.
- DONE:
  - busy=0, init_done=1, data and lcd_rst held.
  - Stays in DONE until start=1 → RST_LOW (full restart, init_done cleared).
- Delay timing: a cycle prescaler (0..CLK_PER_MS-1) with an ms counter; the ms counter is sized for max(T_RST_MS, T_SLPOUT_MS). Both counters clear on every state entry.
- Timeout:
  - In WAIT_DONE, a cycle counter runs from the en_write cycle.
  - Reaching WR_TIMEOUT without wr_done → err=1, busy=0, init_done=0, state IDLE. lcd_rst stays 1.
- Simultaneous events:
  - wr_done on the timeout cycle counts as success (no err).
  - wr_done outside WAIT_DONE is ignored.
  - start while busy is ignored.
  - start in IDLE or DONE is always accepted.
- Reset mid-operation: async return to reset values. lcd_rst=1 immediately; no partial word is re-sent.
- Inter-word gap: the new en_write is visible 2 cycles after wr_done (transition to SEND, then registered output). The writer is already idle by then.

Test Plan:
1. CLK_PER_MS=10, T_RST_MS=2, T_SLPOUT_MS=3; pulse start, writer model returns wr_done 20 cycles after en_write → lcd_rst low exactly 20 cycles, high 20 cycles, then 7 en_write pulses with data 011,036,100,03A,105,021,029. Also: ≥30 cycles between wr_done of word 0 and en_write of word 1; init_done=1, busy=0 after the last wr_done.
2. Check en_write width = 1 cycle, and data is unchanged from each en_write until the next en_write (dc never glitches mid-word).
3. Writer model never returns wr_done for word 3 (9'h03A) → err=1 exactly WR_TIMEOUT cycles after its en_write; busy=0, init_done=0. Next start clears err and replays the full sequence.
4. Pulse start during RST_WAIT and during WAIT_DONE → ignored; sequence and word order unchanged.
5. Assert sys_rst during DELAY → all outputs return to reset values asynchronously. A later start produces a complete sequence from lcd_rst low.
6. Pulse start in DONE → init_done drops the next cycle and the full 7-word sequence repeats; a spurious wr_done in DONE has no effect.
